// File: rtl/soc_uart_fifo.sv
// soc_uart_fifo: parametrised UART with a TX FIFO feeding a serialiser, and an
// RX deserialiser with start-bit qualification feeding a single holding
// register. Bus side uses valid/ready streams; line side is uart_TXD/uart_RXD.
module soc_uart_fifo #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic                             ref_clk,
  input  logic                             fpga_reset_n,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic [$clog2(TX_FIFO_DEPTH):0]   tx_fifo_level,
  output logic                             tx_busy,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic                             rx_parity_err,
  output logic                             rx_frame_err,
  output logic                             rx_overrun,
  input  logic                             uart_RXD,
  output logic                             uart_TXD
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV) + 1;
  localparam int AW  = $clog2(TX_FIFO_DEPTH);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] B_LAST      = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   LEVEL_FULL  = (AW + 1)'(TX_FIFO_DEPTH);
  localparam bit            HAS_PAR     = (PARITY != 0);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BRK} rx_state_t;

  // Parity bit for a payload: even -> XOR of data bits, odd -> its inverse.
  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] r_mem [TX_FIFO_DEPTH];
  logic [AW:0]          r_wptr, r_rptr;
  logic [AW:0]          w_level;
  logic                 w_full, w_empty, w_push, w_pop;
  logic [DATA_BITS-1:0] w_fifo_rdata;

  assign w_level      = r_wptr - r_rptr;
  assign w_full       = (w_level == LEVEL_FULL);
  assign w_empty      = (w_level == '0);
  assign w_push       = tx_valid && !w_full;
  assign w_fifo_rdata = r_mem[r_rptr[AW-1:0]];

  // FIFO storage write port.
  // NOTE: storage array has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge ref_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= tx_data;
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge ref_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nxt;
  logic [BW-1:0]        r_tx_bit, w_tx_bit_nxt;
  logic                 r_tx_stop, w_tx_stop_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic                 r_tx_par, w_tx_par_nxt;
  logic                 r_txd, w_txd_nxt;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == C_BIT_LAST);

  // TX state register and serialiser datapath.
  always_ff @(posedge ref_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_stop  <= w_tx_stop_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_par   <= w_tx_par_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // TX next state: pop in IDLE or straight out of the last stop bit so that
  // back-to-back frames leave no idle gap; uart_TXD is registered.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_stop_nxt  = r_tx_stop;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_par_nxt   = r_tx_par;
    w_txd_nxt      = r_txd;
    w_pop          = 1'b0;
    if (r_tx_state != TX_IDLE) w_tx_cnt_nxt = w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = w_fifo_rdata;
          w_tx_par_nxt   = par_of(w_fifo_rdata);
          w_txd_nxt      = 1'b0;
        end
      end
      TX_START: begin
        if (w_tx_bit_end) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_bit_nxt   = '0;
          w_txd_nxt      = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          if (r_tx_bit == B_LAST) begin
            if (HAS_PAR) begin
              w_tx_state_nxt = TX_PARITY;
              w_txd_nxt      = r_tx_par;
            end else begin
              w_tx_state_nxt = TX_STOP;
              w_tx_stop_nxt  = 1'b0;
              w_txd_nxt      = 1'b1;
            end
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 1'b1;
            w_tx_shift_nxt = r_tx_shift >> 1;
            w_txd_nxt      = r_tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_state_nxt = TX_STOP;
          w_tx_stop_nxt  = 1'b0;
          w_txd_nxt      = 1'b1;
        end
      end
      TX_STOP: begin
        if (w_tx_bit_end) begin
          if (STOP_BITS == 1 || r_tx_stop) begin
            if (!w_empty) begin
              w_pop          = 1'b1;
              w_tx_state_nxt = TX_START;
              w_tx_cnt_nxt   = '0;
              w_tx_shift_nxt = w_fifo_rdata;
              w_tx_par_nxt   = par_of(w_fifo_rdata);
              w_txd_nxt      = 1'b0;
            end else begin
              w_tx_state_nxt = TX_IDLE;
              w_txd_nxt      = 1'b1;
            end
          end else begin
            w_tx_stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_txd_nxt      = 1'b1;
      end
    endcase
  end

  assign uart_TXD      = r_txd;
  assign tx_ready      = !w_full;
  assign tx_fifo_level = w_level;
  assign tx_busy       = (r_tx_state != TX_IDLE) || !w_empty;

  // ---------------------------------------------------------------- RX path
  logic [1:0]           r_sync;
  logic                 r_rxd_d;
  logic                 w_rxd;
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [CW-1:0]        r_rx_cnt, w_rx_cnt_nxt;
  logic [BW-1:0]        r_rx_bit, w_rx_bit_nxt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic                 r_rx_parbit, w_rx_parbit_nxt;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic                 r_rx_valid, w_rx_valid_nxt;
  logic                 r_rx_perr, w_rx_perr_nxt;
  logic                 r_rx_ferr, w_rx_ferr_nxt;
  logic                 r_rx_ovr, w_rx_ovr_nxt;
  logic                 w_rx_done;

  assign w_rxd = r_sync[1];

  // Two-flop synchroniser plus a delayed copy for 1->0 edge detection; preset
  // high so reset never looks like a start bit.
  always_ff @(posedge ref_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      r_sync  <= 2'b11;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], uart_RXD};
      r_rxd_d <= w_rxd;
    end
  end

  // RX state register, deserialiser and holding register.
  always_ff @(posedge ref_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_parbit <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_perr   <= 1'b0;
      r_rx_ferr   <= 1'b0;
      r_rx_ovr    <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_state_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_rx_bit    <= w_rx_bit_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rx_parbit <= w_rx_parbit_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_rx_perr   <= w_rx_perr_nxt;
      r_rx_ferr   <= w_rx_ferr_nxt;
      r_rx_ovr    <= w_rx_ovr_nxt;
    end
  end

  // RX next state: qualify the start bit at its centre, then sample each
  // following bit one bit period later; a 0 stop bit parks in BRK until the
  // line returns high so a long break cannot retrigger.
  always_comb begin
    w_rx_state_nxt  = r_rx_state;
    w_rx_cnt_nxt    = r_rx_cnt;
    w_rx_bit_nxt    = r_rx_bit;
    w_rx_shift_nxt  = r_rx_shift;
    w_rx_parbit_nxt = r_rx_parbit;
    w_rx_done       = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rxd_d && !w_rxd) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == C_HALF_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = w_rxd ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == C_BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {w_rxd, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == B_LAST) w_rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
          else                    w_rx_bit_nxt   = r_rx_bit + 1'b1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_PARITY: begin
        if (r_rx_cnt == C_BIT_LAST) begin
          w_rx_cnt_nxt    = '0;
          w_rx_parbit_nxt = w_rxd;
          w_rx_state_nxt  = RX_STOP;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == C_BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_done      = 1'b1;
          w_rx_state_nxt = w_rxd ? RX_IDLE : RX_BRK;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_BRK: begin
        if (w_rxd) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Holding register: a completing frame loads when the register is free or
  // being read this cycle; otherwise it is dropped and overrun latches.
  always_comb begin
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = r_rx_valid;
    w_rx_perr_nxt  = r_rx_perr;
    w_rx_ferr_nxt  = r_rx_ferr;
    w_rx_ovr_nxt   = r_rx_ovr;
    if (r_rx_valid && rx_ready) begin
      w_rx_valid_nxt = 1'b0;
      w_rx_ovr_nxt   = 1'b0;
    end
    if (w_rx_done) begin
      if (!r_rx_valid || rx_ready) begin
        w_rx_data_nxt  = r_rx_shift;
        w_rx_valid_nxt = 1'b1;
        w_rx_perr_nxt  = HAS_PAR && (r_rx_parbit != par_of(r_rx_shift));
        w_rx_ferr_nxt  = !w_rxd;
      end else begin
        w_rx_ovr_nxt = 1'b1;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;
  assign rx_overrun    = r_rx_ovr;

endmodule

// File: tb/tb_soc_uart_fifo.sv
// Directed bench for soc_uart_fifo: one instance without parity (TX timing,
// FIFO burst, RX glitch and overrun) and one with even parity (loopback and
// injected parity/stop errors).
module tb_soc_uart_fifo;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: no parity.
  logic [7:0] tx_data_a, rx_data_a;
  logic       tx_valid_a, tx_ready_a, busy_a, rx_valid_a, rx_ready_a;
  logic       perr_a, ferr_a, ovr_a, rxd_a, txd_a;
  logic [4:0] level_a;

  // Instance P: even parity, RXD either looped from TXD or driven by the bench.
  logic [7:0] tx_data_p, rx_data_p;
  logic       tx_valid_p, tx_ready_p, busy_p, rx_valid_p, rx_ready_p;
  logic       perr_p, ferr_p, ovr_p, rxd_p, txd_p, rxd_pb, loop_p;
  logic [4:0] level_p;

  assign rxd_p = loop_p ? txd_p : rxd_pb;

  soc_uart_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .ref_clk(clk), .fpga_reset_n(rst_n),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .tx_fifo_level(level_a), .tx_busy(busy_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a),
    .uart_RXD(rxd_a), .uart_TXD(txd_a));

  soc_uart_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(2)) dut_p (
    .ref_clk(clk), .fpga_reset_n(rst_n),
    .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
    .tx_fifo_level(level_p), .tx_busy(busy_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
    .rx_parity_err(perr_p), .rx_frame_err(ferr_p), .rx_overrun(ovr_p),
    .uart_RXD(rxd_p), .uart_TXD(txd_p));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_bit(input bit sel_p, input logic b);
    if (sel_p) rxd_pb = b;
    else       rxd_a  = b;
    repeat (DIV) tick();
  endtask

  // Serial frame onto a bench-driven RXD; line left high afterwards.
  task automatic drive_frame(input bit sel_p, input logic [7:0] d, input bit with_par,
                             input logic par_bit, input logic stop_bit);
    drive_bit(sel_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel_p, d[i]);
    if (with_par) drive_bit(sel_p, par_bit);
    drive_bit(sel_p, stop_bit);
    if (sel_p) rxd_pb = 1'b1;
    else       rxd_a  = 1'b1;
  endtask

  task automatic wait_valid(input bit sel_p, input int limit, input string tag);
    int n = 0;
    while (!(sel_p ? rx_valid_p : rx_valid_a) && n < limit) begin
      tick();
      n++;
    end
    check(tag, {31'd0, sel_p ? rx_valid_p : rx_valid_a}, 32'd1);
  endtask

  function automatic logic [7:0] burst_byte(input int i);
    return 8'(i * 37 + 3);
  endfunction

  initial begin
    logic [9:0] fr;
    bit         saw_full;
    int         wi;

    rst_n = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0; rxd_a = 1'b1;
    tx_data_p = '0; tx_valid_p = 1'b0; rx_ready_p = 1'b0; rxd_pb = 1'b1; loop_p = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_txd",    {31'd0, txd_a},      32'd1);
    check("rst_ready",  {31'd0, tx_ready_a}, 32'd1);
    check("rst_level",  {27'd0, level_a},    32'd0);
    check("rst_busy",   {31'd0, busy_a},     32'd0);
    check("rst_rxv",    {31'd0, rx_valid_a}, 32'd0);
    check("rst_rxdata", {24'd0, rx_data_a},  32'd0);
    check("rst_flags",  {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single byte 0xA5: start low two cycles after the write, then LSB first.
    tx_data_a = 8'hA5; tx_valid_a = 1'b1;
    tick();
    tx_valid_a = 1'b0;
    check("a5_idle_n1", {31'd0, txd_a},   32'd1);
    check("a5_level",   {27'd0, level_a}, 32'd1);
    check("a5_busy_n1", {31'd0, busy_a},  32'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 100; k++) begin
      tick();
      check($sformatf("a5_txd_%0d", k), {31'd0, txd_a}, {31'd0, fr[k / 10]});
    end
    check("a5_busy_stop", {31'd0, busy_a}, 32'd1);
    tick();
    check("a5_busy_end", {31'd0, busy_a}, 32'd0);
    check("a5_txd_end",  {31'd0, txd_a},  32'd1);

    // Reset asserted mid-frame with bytes still queued.
    tx_data_a = 8'h0F; tx_valid_a = 1'b1;
    repeat (3) tick();
    tx_valid_a = 1'b0;
    repeat (15) tick();
    check("midrst_level_pre", {27'd0, level_a}, 32'd2);
    check("midrst_busy_pre",  {31'd0, busy_a},  32'd1);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_txd",   {31'd0, txd_a},      32'd1);
    check("midrst_level", {27'd0, level_a},    32'd0);
    check("midrst_ready", {31'd0, tx_ready_a}, 32'd1);
    check("midrst_busy",  {31'd0, busy_a},     32'd0);
    check("midrst_rxv",   {31'd0, rx_valid_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("postrst_txd",  {31'd0, txd_a},  32'd1);
    check("postrst_busy", {31'd0, busy_a}, 32'd0);

    // Burst of 20 writes honouring tx_ready; frames must be back to back.
    saw_full = 1'b0;
    wi = 0;
    fork
      begin : writer
        int cyc = 0;
        while (wi < 20 && cyc < 3000) begin
          tick();
          cyc++;
          check("burst_lvl_le16", {31'd0, (level_a <= 5'd16)}, 32'd1);
          if (level_a == 5'd16) begin
            saw_full = 1'b1;
            check("burst_ready_full", {31'd0, tx_ready_a}, 32'd0);
          end
          if (tx_ready_a) begin
            tx_valid_a = 1'b1;
            tx_data_a  = burst_byte(wi);
            wi++;
          end else begin
            tx_valid_a = 1'b0;
          end
        end
        tick();
        tx_valid_a = 1'b0;
      end
      begin : monitor
        int n = 0;
        logic [9:0] mf;
        while (txd_a !== 1'b0 && n < 50) begin
          tick();
          n++;
        end
        check("burst_start", {31'd0, txd_a}, 32'd0);
        for (int t = 0; t < 2000; t++) begin
          mf = {1'b1, burst_byte(t / 100), 1'b0};
          check($sformatf("burst_txd_f%0d_c%0d", t / 100, t % 100), {31'd0, txd_a},
                {31'd0, mf[(t % 100) / 10]});
          tick();
        end
      end
    join
    check("burst_all_written", wi, 20);
    check("burst_saw_full", {31'd0, saw_full}, 32'd1);
    check("burst_busy_end", {31'd0, busy_a}, 32'd0);
    check("burst_level_end", {27'd0, level_a}, 32'd0);

    // Even parity loopback of 0x3C.
    loop_p = 1'b1;
    tx_data_p = 8'h3C; tx_valid_p = 1'b1;
    tick();
    tx_valid_p = 1'b0;
    wait_valid(1'b1, 200, "loop_valid");
    check("loop_data", {24'd0, rx_data_p}, 32'h3C);
    check("loop_perr", {31'd0, perr_p},    32'd0);
    check("loop_ferr", {31'd0, ferr_p},    32'd0);
    repeat (DIV) tick();
    loop_p = 1'b0;
    rx_ready_p = 1'b1; tick(); rx_ready_p = 1'b0;
    check("loop_read", {31'd0, rx_valid_p}, 32'd0);

    // Flipped parity bit (correct even parity of 0x3C is 0).
    repeat (5) tick();
    drive_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    wait_valid(1'b1, 20, "perr_valid");
    check("perr_data", {24'd0, rx_data_p}, 32'h3C);
    check("perr_flag", {31'd0, perr_p},    32'd1);
    check("perr_ferr", {31'd0, ferr_p},    32'd0);
    rx_ready_p = 1'b1; tick(); rx_ready_p = 1'b0;

    // Stop bit sampled low.
    repeat (5) tick();
    drive_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    wait_valid(1'b1, 20, "ferr_valid");
    check("ferr_flag", {31'd0, ferr_p}, 32'd1);
    check("ferr_perr", {31'd0, perr_p}, 32'd0);
    rx_ready_p = 1'b1; tick(); rx_ready_p = 1'b0;
    check("ferr_read", {31'd0, rx_valid_p}, 32'd0);

    // Start-bit glitch, then a clean frame proves the receiver returned to idle.
    rxd_a = 1'b0;
    repeat (3) tick();
    rxd_a = 1'b1;
    repeat (30) tick();
    check("glitch_novalid", {31'd0, rx_valid_a}, 32'd0);
    drive_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, 20, "clean_valid");
    check("clean_data", {24'd0, rx_data_a}, 32'h5A);
    check("clean_flags", {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
    rx_ready_a = 1'b1; tick(); rx_ready_a = 1'b0;
    check("clean_read", {31'd0, rx_valid_a}, 32'd0);

    // Overrun: second frame dropped while the first is unread.
    repeat (5) tick();
    drive_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, 20, "ovr_first_valid");
    check("ovr_first_data", {24'd0, rx_data_a}, 32'h11);
    check("ovr_first_flag", {31'd0, ovr_a},     32'd0);
    drive_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check("ovr_keep_data", {24'd0, rx_data_a},  32'h11);
    check("ovr_flag",      {31'd0, ovr_a},      32'd1);
    check("ovr_valid",     {31'd0, rx_valid_a}, 32'd1);
    rx_ready_a = 1'b1; tick(); rx_ready_a = 1'b0;
    check("ovr_read_valid", {31'd0, rx_valid_a}, 32'd0);
    check("ovr_read_clear", {31'd0, ovr_a},      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
